// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared PC width, FSM state encodings and queue entry layout
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package branch_resolve_pkg;

  localparam int PC_SIZE = `PC_SIZE;

  typedef enum logic [1:0] {
    RS_IDLE     = 2'd0,
    RS_REDIRECT = 2'd1,
    RS_DRAIN    = 2'd2
  } rs_state_e;

  // One outstanding fetch prediction, oldest at the queue head.
  typedef struct packed {
    logic [PC_SIZE-1:0] pc;
    logic               taken;
    logic [PC_SIZE-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - fetch/EX handshake bundle for branch_resolve
interface branch_resolve_if
  import branch_resolve_pkg::*;
#(
  parameter int PC_W = PC_SIZE
);

  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            pred_ready;
  logic            res_valid;
  logic [PC_W-1:0] res_pc;
  logic            res_taken;
  logic [PC_W-1:0] res_target;
  logic            pc_sel;
  logic [PC_W-1:0] ex_pc;
  logic            flush;
  logic            busy;
  logic [31:0]     br_cnt;
  logic [31:0]     mis_cnt;
  logic            err;

  // Pipeline side: fetch pushes predictions, EX reports outcomes.
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_taken, res_target,
    input  pred_ready, pc_sel, ex_pc, flush, busy, br_cnt, mis_cnt, err
  );

  // Resolver side.
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_taken, res_target,
    output pred_ready, pc_sel, ex_pc, flush, busy, br_cnt, mis_cnt, err
  );

endinterface

// File: rtl/branch_resolve_pred_fifo.sv
// rtl/branch_resolve_pred_fifo.sv - in-order prediction tracking queue with bulk clear
module branch_resolve_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // Pointer/occupancy bookkeeping; clear wins so a squash empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage; a push while full relies on the same-cycle pop vacating the head slot.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - compares EX outcomes with fetch predictions and drives redirect
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int PC_W      = PC_SIZE,
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 2
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } entry_t;

  rs_state_e       state;
  logic [DCW-1:0]  drain_cnt;
  logic            pc_sel_q;
  logic            flush_q;
  logic            err_q;
  logic [PC_W-1:0] ex_pc_q;
  logic [31:0]     br_cnt_q;
  logic [31:0]     mis_cnt_q;

  entry_t          push_entry;
  entry_t          head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            idle;
  logic            res_acc;
  logic            pred_ready_c;
  logic            push_acc;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] correct_next;
  logic            pc_mismatch;
  logic            mispredict;
  logic            redirect;
  logic            proto_err;

  assign idle         = (state == RS_IDLE);
  assign res_acc      = idle & bus.res_valid & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a full queue can still take a push.
  assign pred_ready_c = idle & (~fifo_full | res_acc);
  assign push_acc     = bus.pred_valid & pred_ready_c;
  assign push_entry   = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  assign seq_pc       = bus.res_pc + PC_W'(4);
  assign correct_next = bus.res_taken ? bus.res_target : seq_pc;
  assign pc_mismatch  = (bus.res_pc != head.pc);
  assign mispredict   = (bus.res_taken != head.taken) |
                        (head.taken ? (head.target != correct_next) : (head.target != seq_pc));
  // A PC mismatch means the queue is out of step with EX; recover the same way as a mispredict.
  assign redirect     = res_acc & (mispredict | pc_mismatch);
  assign proto_err    = (idle & bus.res_valid & fifo_empty) | (res_acc & pc_mismatch);

  branch_resolve_pred_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_acc & ~redirect),
    .push_data(push_entry),
    .pop      (res_acc),
    .clear    (redirect),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Recovery FSM with registered redirect outputs, statistics and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RS_IDLE;
      drain_cnt <= '0;
      pc_sel_q  <= 1'b0;
      flush_q   <= 1'b0;
      ex_pc_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pc_sel_q <= 1'b0;
      flush_q  <= 1'b0;
      if (res_acc && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (proto_err) err_q <= 1'b1;
      case (state)
        RS_IDLE: begin
          if (redirect) begin
            state    <= RS_REDIRECT;
            pc_sel_q <= 1'b1;
            flush_q  <= 1'b1;
            ex_pc_q  <= correct_next;
            if (mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_q <= mis_cnt_q + 32'd1;
          end
        end
        RS_REDIRECT: begin
          drain_cnt <= DCW'(DRAIN_CYC - 1);
          state     <= RS_DRAIN;
        end
        RS_DRAIN: begin
          if (drain_cnt == '0) state <= RS_IDLE;
          else                 drain_cnt <= drain_cnt - DCW'(1);
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  assign bus.pred_ready = pred_ready_c;
  assign bus.pc_sel     = pc_sel_q;
  assign bus.flush      = flush_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.busy       = ~idle;
  assign bus.br_cnt     = br_cnt_q;
  assign bus.mis_cnt    = mis_cnt_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

  localparam int PC_W      = 32;
  localparam int DEPTH     = 4;
  localparam int DRAIN_CYC = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolve_if #(.PC_W(PC_W)) bus ();

  branch_resolve #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit        pv;
    bit [31:0] ppc;
    bit        pt;
    bit [31:0] ptg;
    bit        rv;
    bit [31:0] rpc;
    bit        rt;
    bit [31:0] rtg;
    bit        e_ready;
    bit        e_sel;
    bit [31:0] e_expc;
    bit        e_busy;
    int        e_br;
    int        e_mis;
    bit        e_err;
  } vec_t;

  typedef struct {
    bit [31:0] pc;
    bit        taken;
    bit [31:0] target;
  } ent_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of outstanding predictions plus a count of blocked cycles.
  ent_t      mq[$];
  int        blocked;
  bit        m_pulse;
  bit [31:0] m_expc;
  bit [31:0] m_br;
  bit [31:0] m_mis;
  bit        m_err;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    blocked = 0;
    m_pulse = 1'b0;
    m_expc  = '0;
    m_br    = '0;
    m_mis   = '0;
    m_err   = 1'b0;
  endtask

  task automatic drive_idle();
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.res_valid   = 1'b0;
    bus.res_pc      = '0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, check ready, advance model, check registered outputs after edge.
  task automatic step(input vec_t v, output bit got_ready);
    bit        exp_ready;
    bit        redir;
    bit [31:0] nxt;
    ent_t      h;
    @(negedge clk);
    bus.pred_valid  = v.pv;
    bus.pred_pc     = v.ppc;
    bus.pred_taken  = v.pt;
    bus.pred_target = v.ptg;
    bus.res_valid   = v.rv;
    bus.res_pc      = v.rpc;
    bus.res_taken   = v.rt;
    bus.res_target  = v.rtg;
    #1;
    exp_ready = (blocked == 0) && ((mq.size() < DEPTH) || (v.rv && mq.size() > 0));
    got_ready = bus.pred_ready;
    chk("pred_ready", 32'(bus.pred_ready), 32'(exp_ready));
    redir = 1'b0;
    if (blocked == 0) begin
      if (v.rv) begin
        if (mq.size() == 0) m_err = 1'b1;
        else begin
          h = mq.pop_front();
          if (m_br != 32'hFFFF_FFFF) m_br++;
          nxt = v.rt ? v.rtg : v.rpc + 32'd4;
          if (v.rpc != h.pc) m_err = 1'b1;
          if (v.rpc != h.pc || v.rt != h.taken || h.target != nxt) begin
            mq.delete();
            redir   = 1'b1;
            blocked = 1 + DRAIN_CYC;
            if (m_mis != 32'hFFFF_FFFF) m_mis++;
            m_expc = nxt;
          end
        end
      end
      if (v.pv && exp_ready && !redir) mq.push_back('{v.ppc, v.pt, v.ptg});
    end else begin
      blocked--;
    end
    m_pulse = redir;
    @(posedge clk);
    #1;
    chk("pc_sel", 32'(bus.pc_sel), 32'(m_pulse));
    chk("flush", 32'(bus.flush), 32'(m_pulse));
    if (m_pulse) chk("ex_pc", bus.ex_pc, m_expc);
    chk("busy", 32'(bus.busy), 32'(blocked > 0));
    chk("br_cnt", bus.br_cnt, m_br);
    chk("mis_cnt", bus.mis_cnt, m_mis);
    chk("err", 32'(bus.err), 32'(m_err));
  endtask

  function automatic vec_t mk(input bit pv, input bit [31:0] ppc, input bit pt, input bit [31:0] ptg,
                              input bit rv, input bit [31:0] rpc, input bit rt, input bit [31:0] rtg);
    vec_t v;
    v = '{pv, ppc, pt, ptg, rv, rpc, rt, rtg, 0, 0, 0, 0, 0, 0, 0};
    return v;
  endfunction

  initial begin
    bit   r;
    vec_t v;
    ent_t h;
    int   c;

    // pv ppc pt ptg | rv rpc rt rtg | ready sel expc busy br mis err
    vt.push_back('{1, 'h100, 1, 'hF0,  0, 0,     0, 0,     1, 0, 0,     0, 0, 0, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h100, 1, 'hF0,  1, 0, 0,     0, 1, 0, 0});
    vt.push_back('{1, 'h200, 0, 'h204, 0, 0,     0, 0,     1, 0, 0,     0, 1, 0, 0});
    vt.push_back('{1, 'h300, 1, 'h2F0, 0, 0,     0, 0,     1, 0, 0,     0, 1, 0, 0});
    vt.push_back('{1, 'h400, 0, 'h404, 0, 0,     0, 0,     1, 0, 0,     0, 1, 0, 0});
    vt.push_back('{1, 'h500, 0, 'h504, 1, 'h200, 1, 'h280, 1, 1, 'h280, 1, 2, 1, 0});
    vt.push_back('{1, 'h600, 0, 'h604, 0, 0,     0, 0,     0, 0, 0,     1, 2, 1, 0});
    vt.push_back('{1, 'h600, 0, 'h604, 1, 'h600, 0, 0,     0, 0, 0,     1, 2, 1, 0});
    vt.push_back('{0, 0,     0, 0,     0, 0,     0, 0,     0, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h10,  1, 'h8,   0, 0,     0, 0,     1, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h20,  0, 'h24,  0, 0,     0, 0,     1, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h30,  0, 'h34,  0, 0,     0, 0,     1, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h40,  1, 'h38,  0, 0,     0, 0,     1, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h50,  0, 'h54,  0, 0,     0, 0,     0, 0, 0,     0, 2, 1, 0});
    vt.push_back('{1, 'h50,  0, 'h54,  1, 'h10,  1, 'h8,   1, 0, 0,     0, 3, 1, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h20,  0, 0,     1, 0, 0,     0, 4, 1, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h30,  0, 0,     1, 0, 0,     0, 5, 1, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h40,  1, 'h38,  1, 0, 0,     0, 6, 1, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h50,  0, 0,     1, 0, 0,     0, 7, 1, 0});
    vt.push_back('{0, 0,     0, 0,     1, 'h999, 0, 0,     1, 0, 0,     0, 7, 1, 1});

    rst = 1'b1;
    drive_idle();
    model_reset();
    do_reset();

    #1;
    chk("reset pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("reset ex_pc", bus.ex_pc, 32'd0);
    chk("reset flush", 32'(bus.flush), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset br_cnt", bus.br_cnt, 32'd0);
    chk("reset mis_cnt", bus.mis_cnt, 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset pred_ready", 32'(bus.pred_ready), 32'd1);

    foreach (vt[i]) begin
      step(vt[i], r);
      chk($sformatf("vec%0d ready", i), 32'(r), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d pc_sel", i), 32'(bus.pc_sel), 32'(vt[i].e_sel));
      if (vt[i].e_sel) chk($sformatf("vec%0d ex_pc", i), bus.ex_pc, vt[i].e_expc);
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d br_cnt", i), bus.br_cnt, 32'(vt[i].e_br));
      chk($sformatf("vec%0d mis_cnt", i), bus.mis_cnt, 32'(vt[i].e_mis));
      chk($sformatf("vec%0d err", i), 32'(bus.err), 32'(vt[i].e_err));
    end

    // Wrap-around: ten correct push/resolve pairs walk the pointers past DEPTH twice.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bit [31:0] pc;
      bit        tk;
      bit [31:0] tg;
      pc = (i == 9) ? 32'hFFFF_FFFC : 32'h1000 + 32'(i * 8);
      tk = i[0];
      tg = tk ? pc - 32'h20 : pc + 32'd4;
      step(mk(1, pc, tk, tg, 0, 0, 0, 0), r);
      step(mk(0, 0, 0, 0, 1, pc, tk, tg), r);
    end
    chk("wrap br_cnt", bus.br_cnt, 32'd10);
    chk("wrap mis_cnt", bus.mis_cnt, 32'd0);
    chk("wrap err", 32'(bus.err), 32'd0);

    // Protocol errors: resolve on empty queue, then a head PC mismatch.
    step(mk(0, 0, 0, 0, 1, 'h300, 1, 'h400), r);
    chk("empty err", 32'(bus.err), 32'd1);
    chk("empty br_cnt", bus.br_cnt, 32'd10);
    step(mk(1, 'h304, 1, 'h400, 0, 0, 0, 0), r);
    step(mk(0, 0, 0, 0, 1, 'h300, 1, 'h400), r);
    chk("pcmm pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("pcmm ex_pc", bus.ex_pc, 32'h400);
    chk("pcmm mis_cnt", bus.mis_cnt, 32'd1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), r);
    chk("drain busy", 32'(bus.busy), 32'd1);

    // Asynchronous reset while draining.
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("arst flush", 32'(bus.flush), 32'd0);
    chk("arst br_cnt", bus.br_cnt, 32'd0);
    chk("arst mis_cnt", bus.mis_cnt, 32'd0);
    chk("arst err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(mk(1, 'h700, 0, 'h704, 0, 0, 0, 0), r);
    step(mk(0, 0, 0, 0, 1, 'h700, 0, 0), r);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      v     = mk(0, 0, 0, 0, 0, 0, 0, 0);
      v.pv  = 1'($urandom_range(0, 1));
      v.ppc = $urandom() & 32'hFFFF_FFFC;
      v.pt  = 1'($urandom_range(0, 1));
      v.ptg = v.pt ? ($urandom() & 32'hFFFF_FFFC) : v.ppc + 32'd4;
      if ($urandom_range(0, 9) == 0) v.ptg = $urandom();
      v.rv  = ($urandom_range(0, 9) < 4);
      if (v.rv && mq.size() > 0) begin
        h     = mq[0];
        c     = int'($urandom_range(0, 9));
        v.rpc = (c == 0) ? (h.pc ^ 32'd4) : h.pc;
        if (c > 0 && c < 8) begin
          v.rt  = h.taken;
          v.rtg = h.taken ? h.target : $urandom();
        end else begin
          v.rt  = 1'($urandom_range(0, 1));
          v.rtg = $urandom();
        end
      end else begin
        v.rpc = $urandom();
        v.rt  = 1'($urandom_range(0, 1));
        v.rtg = $urandom();
      end
      step(v, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
